// File: rtl/demuxf7_pkg.sv
// Shared constants and helpers for the demuxf7 serial-to-parallel fabric cell.
// Lane indices are carried in a fixed 3-bit field regardless of LANES.
package demuxf7_pkg;

  localparam int DEMUXF7_LANES_MAX = 8;
  localparam int DEMUXF7_LANE_W    = 3;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic bit lanes_legal(input int lanes);
    return (lanes >= 2) && (lanes <= DEMUXF7_LANES_MAX) &&
           (clog2(lanes) <= DEMUXF7_LANE_W);
  endfunction

endpackage

// File: rtl/demuxf7_lane_cnt.sv
// Lane steering counter: advances on each accepted bit, wraps after the last
// lane, and restarts at lane 0 on SYNC. The count itself is the state.
module demuxf7_lane_cnt
  import demuxf7_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic                      iv,
  input  logic                      sync,
  output logic [DEMUXF7_LANE_W-1:0] lane,
  output logic                      last
);

  localparam logic [DEMUXF7_LANE_W-1:0] LAST_LANE = DEMUXF7_LANE_W'(LANES - 1);

  logic [DEMUXF7_LANE_W-1:0] lane_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
    end else if (ce) begin
      if (sync) begin
        // A bit arriving with SYNC occupies lane 0, so the next one goes to lane 1.
        lane_q <= iv ? DEMUXF7_LANE_W'(1) : '0;
      end else if (iv) begin
        lane_q <= (lane_q == LAST_LANE) ? '0 : lane_q + 1'b1;
      end
    end
  end

  assign lane = lane_q;
  assign last = (lane_q == LAST_LANE);

endmodule

// File: rtl/demuxf7_deser.sv
// Registered 1-to-LANES demux/deserializer: collects serial bits into a word
// and presents each completed word on O/LO with a valid/ready handshake.
module demuxf7_deser
  import demuxf7_pkg::*;
#(
  parameter int LANES     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                      C,
  input  logic                      R,
  input  logic                      CE,
  input  logic                      I,
  input  logic                      IV,
  input  logic                      SYNC,
  input  logic                      OREADY,
  output logic [LANES-1:0]          O,
  output logic [LANES-1:0]          LO,
  output logic                      OV,
  output logic                      OVF,
  output logic [DEMUXF7_LANE_W-1:0] LANE
);

  generate
    if (!lanes_legal(LANES)) begin : g_bad_lanes
      $error("demuxf7_deser: LANES must be in 2..%0d", DEMUXF7_LANES_MAX);
    end
  endgenerate

  logic [DEMUXF7_LANE_W-1:0] lane;
  logic                      last;
  logic [LANES-1:0]          acc_q;
  logic [LANES-1:0]          acc_nxt;
  logic [LANES-1:0]          o_q;
  logic                      ov_q;
  logic                      ovf_q;
  logic                      complete;
  int                        bit_idx;

  demuxf7_lane_cnt #(.LANES(LANES)) u_lane_cnt (
    .clk  (C),
    .rst  (R),
    .ce   (CE),
    .iv   (IV),
    .sync (SYNC),
    .lane (lane),
    .last (last)
  );

  // SYNC drops the partial word first, then the incoming bit lands in lane 0.
  always_comb begin
    acc_nxt = SYNC ? '0 : acc_q;
    bit_idx = 0;
    if (!SYNC) begin
      bit_idx = LSB_FIRST ? int'(lane) : (LANES - 1 - int'(lane));
    end else if (!LSB_FIRST) begin
      bit_idx = LANES - 1;
    end
    if (IV) begin
      for (int j = 0; j < LANES; j++) begin
        if (j == bit_idx) acc_nxt[j] = I;
      end
    end
  end

  assign complete = CE & IV & ~SYNC & last;

  // Handshake: OV=1 means O holds a word not yet taken; an edge with
  // OV & OREADY & CE transfers it. O never changes while OV=1 and not taken.
  always_ff @(posedge C) begin
    if (R) begin
      acc_q <= '0;
      o_q   <= '0;
      ov_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else if (CE) begin
      acc_q <= complete ? '0 : acc_nxt;
      if (complete) begin
        if (!ov_q || OREADY) begin
          o_q  <= acc_nxt;
          ov_q <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (ov_q && OREADY) begin
        ov_q <= 1'b0;
      end
    end
  end

  assign O    = o_q;
  assign LO   = o_q;
  assign OV   = ov_q;
  assign OVF  = ovf_q;
  assign LANE = lane;

endmodule

// File: tb/tb_demuxf7_deser.sv
// Bench for demuxf7_deser: two instances (LSB-first and MSB-first) share one
// serial stream; a monitor checks each presented word against expected queues.
module tb_demuxf7_deser;

  logic       clk = 1'b0;
  logic       r = 1'b1;
  logic       ce = 1'b1;
  logic       i = 1'b0;
  logic       iv = 1'b0;
  logic       sync = 1'b0;
  logic       oready = 1'b1;

  logic [3:0] o_a, lo_a, o_b, lo_b;
  logic       ov_a, ovf_a, ov_b, ovf_b;
  logic [2:0] lane_a, lane_b;

  logic [3:0] exp_a[$];
  logic [3:0] exp_b[$];

  int n_cmp = 0;
  int n_bad = 0;

  demuxf7_deser #(.LANES(4), .LSB_FIRST(1'b1)) dut_a (
    .C(clk), .R(r), .CE(ce), .I(i), .IV(iv), .SYNC(sync), .OREADY(oready),
    .O(o_a), .LO(lo_a), .OV(ov_a), .OVF(ovf_a), .LANE(lane_a)
  );

  demuxf7_deser #(.LANES(4), .LSB_FIRST(1'b0)) dut_b (
    .C(clk), .R(r), .CE(ce), .I(i), .IV(iv), .SYNC(sync), .OREADY(oready),
    .O(o_b), .LO(lo_b), .OV(ov_b), .OVF(ovf_b), .LANE(lane_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    iv = 1'b1;
    i  = b;
    tick();
    iv = 1'b0;
    i  = 1'b0;
    repeat (gap) tick();
  endtask

  // b[0] is sent first
  task automatic send4(input logic [3:0] b, input int gap);
    for (int k = 0; k < 4; k++) send_bit(b[k], (k == 3) ? 0 : gap);
  endtask

  task automatic do_reset();
    r = 1'b1;
    tick();
    r = 1'b0;
  endtask

  // scoreboard monitor: a word is presented when OV rises or is refilled
  logic pa_ov = 1'b0, pa_take = 1'b0, pb_ov = 1'b0, pb_take = 1'b0;

  always @(negedge clk) begin
    logic [3:0] e;
    if (ov_a && (!pa_ov || pa_take)) begin
      if (exp_a.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL word_a: unexpected word %0h", o_a);
      end else begin
        e = exp_a.pop_front();
        check("word_a", {28'd0, o_a}, {28'd0, e});
        check("lo_a", {28'd0, lo_a}, {28'd0, e});
      end
    end
    if (ov_b && (!pb_ov || pb_take)) begin
      if (exp_b.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL word_b: unexpected word %0h", o_b);
      end else begin
        e = exp_b.pop_front();
        check("word_b", {28'd0, o_b}, {28'd0, e});
        check("lo_b", {28'd0, lo_b}, {28'd0, e});
      end
    end
    pa_ov   = ov_a;
    pa_take = ov_a & oready & ce & ~r;
    pb_ov   = ov_b;
    pb_take = ov_b & oready & ce & ~r;
  end

  initial begin
    repeat (2) tick();
    r = 1'b0;
    check("rst_o", {28'd0, o_a}, 32'd0);
    check("rst_ov", {31'd0, ov_a}, 32'd0);
    check("rst_ovf", {31'd0, ovf_a}, 32'd0);
    check("rst_lane", {29'd0, lane_a}, 32'd0);

    // back-to-back bits 1,0,1,1
    oready = 1'b1;
    exp_a.push_back(4'hD); exp_b.push_back(4'hB);
    send4(4'b1101, 0);
    check("t1_ov", {31'd0, ov_a}, 32'd1);
    check("t1_lane", {29'd0, lane_a}, 32'd0);
    check("t1_ovf", {31'd0, ovf_a}, 32'd0);
    tick();
    check("t1_ov_one_cycle", {31'd0, ov_a}, 32'd0);

    // same bits with 3 idle cycles between them
    exp_a.push_back(4'hD); exp_b.push_back(4'hB);
    send_bit(1'b1, 3); check("t2_lane1", {29'd0, lane_b}, 32'd1);
    send_bit(1'b0, 3); check("t2_lane2", {29'd0, lane_b}, 32'd2);
    send_bit(1'b1, 3); check("t2_lane3", {29'd0, lane_b}, 32'd3);
    send_bit(1'b1, 0);
    check("t2_o_b", {28'd0, o_b}, 32'hB);
    tick();
    do_reset();

    // overflow: second word dropped while first is held
    oready = 1'b0;
    exp_a.push_back(4'hA); exp_b.push_back(4'h5);
    send4(4'hA, 0);
    send4(4'h5, 0);
    check("t3_o_a", {28'd0, o_a}, 32'hA);
    check("t3_o_b", {28'd0, o_b}, 32'h5);
    check("t3_ov", {31'd0, ov_a}, 32'd1);
    check("t3_ovf_a", {31'd0, ovf_a}, 32'd1);
    check("t3_ovf_b", {31'd0, ovf_b}, 32'd1);
    check("t3_lane", {29'd0, lane_a}, 32'd0);
    oready = 1'b1;
    tick();
    oready = 1'b0;
    check("t3_ov_taken", {31'd0, ov_a}, 32'd0);
    repeat (3) tick();
    check("t3_ovf_sticky", {31'd0, ovf_a}, 32'd1);
    do_reset();
    check("t3_ovf_cleared", {31'd0, ovf_a}, 32'd0);

    // accept and completion on the same edge
    exp_a.push_back(4'h9); exp_b.push_back(4'h9);
    send4(4'h9, 0);
    exp_a.push_back(4'h3); exp_b.push_back(4'hC);
    send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
    check("t4_hold", {28'd0, o_a}, 32'h9);
    oready = 1'b1;
    send_bit(1'b0, 0);
    check("t4_o_a", {28'd0, o_a}, 32'h3);
    check("t4_o_b", {28'd0, o_b}, 32'hC);
    check("t4_ov", {31'd0, ov_a}, 32'd1);
    check("t4_ovf", {31'd0, ovf_a}, 32'd0);
    tick();
    check("t4_ov_drop", {31'd0, ov_a}, 32'd0);

    // SYNC with a bit after two bits
    send_bit(1'b1, 0); send_bit(1'b1, 0);
    check("t5_lane2", {29'd0, lane_a}, 32'd2);
    exp_a.push_back(4'h9); exp_b.push_back(4'h9);
    sync = 1'b1;
    send_bit(1'b1, 0);
    sync = 1'b0;
    check("t5_lane_sync", {29'd0, lane_a}, 32'd1);
    send_bit(1'b0, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
    check("t5_o", {28'd0, o_a}, 32'h9);
    tick();

    // SYNC on the last lane suppresses completion
    send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
    sync = 1'b1;
    send_bit(1'b0, 0);
    sync = 1'b0;
    check("t5b_lane", {29'd0, lane_a}, 32'd1);
    check("t5b_no_ov", {31'd0, ov_a}, 32'd0);
    exp_a.push_back(4'h6); exp_b.push_back(4'h6);
    send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
    check("t5b_o", {28'd0, o_a}, 32'h6);
    tick();

    // CE=0 freezes everything
    oready = 1'b0;
    exp_a.push_back(4'h7); exp_b.push_back(4'hE);
    send4(4'h7, 0);
    send_bit(1'b0, 0); send_bit(1'b1, 0);
    ce = 1'b0; oready = 1'b1; iv = 1'b1; i = 1'b1; sync = 1'b1;
    repeat (5) tick();
    check("t6_lane", {29'd0, lane_a}, 32'd2);
    check("t6_ov", {31'd0, ov_a}, 32'd1);
    check("t6_o", {28'd0, o_a}, 32'h7);
    check("t6_ovf", {31'd0, ovf_a}, 32'd0);
    ce = 1'b1; iv = 1'b0; i = 1'b0; sync = 1'b0;
    tick();
    check("t6_taken", {31'd0, ov_a}, 32'd0);
    exp_a.push_back(4'h6); exp_b.push_back(4'h6);
    send_bit(1'b1, 0); send_bit(1'b0, 0);
    check("t6_resume", {28'd0, o_a}, 32'h6);
    tick();

    // reset mid-word with CE=0 and a pending word
    oready = 1'b0;
    exp_a.push_back(4'hD); exp_b.push_back(4'hB);
    send4(4'hD, 0);
    send_bit(1'b1, 0); send_bit(1'b1, 0);
    ce = 1'b0; r = 1'b1; iv = 1'b1; i = 1'b1;
    tick();
    r = 1'b0; ce = 1'b1; iv = 1'b0; i = 1'b0;
    check("t7_o_a", {28'd0, o_a}, 32'd0);
    check("t7_lo_a", {28'd0, lo_a}, 32'd0);
    check("t7_o_b", {28'd0, o_b}, 32'd0);
    check("t7_ov", {31'd0, ov_a}, 32'd0);
    check("t7_ovf", {31'd0, ovf_a}, 32'd0);
    check("t7_lane", {29'd0, lane_a}, 32'd0);
    oready = 1'b1;
    exp_a.push_back(4'h1); exp_b.push_back(4'h8);
    send4(4'h1, 0);
    repeat (2) tick();

    check("queue_a_empty", exp_a.size(), 32'd0);
    check("queue_b_empty", exp_b.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demuxf7_deser.md
Name: demuxf7_deser

Overview:
- Registered 1-to-LANES demultiplexer and deserializer. It is the receive-side counterpart of the MUXF7-style parallel-to-serial selection tree.
- A serial bit stream is steered lane by lane into a holding register. Each completed parallel word is presented with a valid/ready handshake.
- Sits in the carry/fabric primitive library as a clock-enabled fabric cell. Output O feeds general routing; LO carries the identical value for local, fast-path routing.

Parameters:
- LANES, 4, number of demux lanes (bits per output word); legal 2..8
- LSB_FIRST, 1, 1 = first serial bit lands in lane 0; 0 = first bit lands in lane LANES-1

Ports:
- C  input  1  clock; all state updates on rising edge
- R  input  1  reset; synchronous, active-high
- CE  input  1  clock enable; gates every state update except R
- I  input  1  serial data bit
- IV  input  1  serial bit valid; I is sampled when IV & CE
- SYNC  input  1  frame align; restarts lane steering at lane 0
- OREADY  input  1  downstream accepts current word
- O  output  LANES  parallel word, general routing
- LO  output  LANES  parallel word, local routing; always equal to O
- OV  output  1  O holds an unaccepted word
- OVF  output  1  sticky: a completed word was dropped
- LANE  output  3  current lane index (next bit destination count), 0..LANES-1

Behaviour:
- Reset: R=1 at an edge sets O=0, LO=0, OV=0, OVF=0, LANE=0 and clears the accumulator. R overrides CE, IV, SYNC and OREADY.
- Enable: with CE=0, all registers hold; IV, SYNC and OREADY are ignored.
- The lane counter is the only state machine: states 0..LANES-1, advancing on each accepted bit.
  - Accepted bit (CE & IV) at lane k writes acc[k] (LSB_FIRST=1) or acc[LANES-1-k] (LSB_FIRST=0).
  - LANE then becomes k+1, wrapping to 0 after LANES-1.
- Word completion: the accepted bit at lane LANES-1 completes a word.
  - Completed word = acc with the final bit merged in.
  - Latency: O/OV update at the same edge that samples the last bit; visible the following cycle.
  - The accumulator clears on completion.
- Handshake: OV=1 & OREADY=1 & CE=1 at an edge accepts the word, and OV falls unless a new word completes at that same edge.
  - Simultaneous accept and completion: O takes the new word and OV stays 1. No bubble, no OVF.
  - Completion while OV=1 & OREADY=0: the new word is discarded, O is unchanged and OVF is set. LANE still wraps to 0.
  - OVF clears only on R.
  - O is stable while OV=1 and not accepted. O retains its last value after acceptance.
- SYNC (with CE):
  - Discards any partial word and forces lane 0. It does not affect O, OV or OVF.
  - SYNC & IV in the same cycle: the bit is taken as lane 0 and LANE becomes 1.
  - If LANE was LANES-1 with IV=1, SYNC wins: no completion, and the bit becomes lane 0 of the next word.
- IV=0: the accumulator and LANE hold; gaps between bits are unlimited.
- Unused upper LANE bits are 0.
- Mid-operation reset: a partial word and any pending O/OV are lost; there is no completion on the reset edge.

Decomposition:
- Shared package demuxf7_pkg:
  - DEMUXF7_LANES_MAX = 8 and DEMUXF7_LANE_W = 3
  - clog2 function
  - elaboration check that LANES is in 2..8
- One natural sub-module: demuxf7_lane_cnt. It implements the lane counter with wrap, SYNC restart and a last-lane flag.
- The top level holds the accumulator, output holding register and handshake/OVF logic.

Test Plan:
- LANES=4, LSB_FIRST=1, OREADY=1; IV=1 with I=1,0,1,1 on 4 consecutive edges -> O=LO=4'b1101, OV=1 for exactly 1 cycle, LANE back to 0, OVF=0.
- LANES=4, LSB_FIRST=0, same bits with IV gaps of 3 idle cycles between bits -> O=4'b1011 after the 4th bit; LANE holds through the gaps.
- OREADY=0; send word 4'hA then word 4'h5 -> O stays 4'hA, OV=1, OVF=1. Then OREADY=1 for one cycle -> OV=0, OVF stays 1 until R.
- OV=1, OREADY=1 on the same edge the 4th bit of 4'h3 arrives -> O=4'h3, OV remains 1, OVF=0.
- After 2 bits (LANE=2), assert SYNC with IV=1, I=1, then 3 more bits 0,0,1 -> O=4'b1001 (SYNC bit is lane 0), and the partial word is discarded.
- Mid-word R=1 with CE=0, and separately CE=0 with IV=1 for 5 cycles -> R clears all outputs to 0 regardless of CE; under CE=0 without R, nothing changes.
